fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL provide parameter DRAIN_CYCLES, default 2, the number of cycles allowed for older instructions to drain after a halt.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous and active-low.
REQ-005 start_i  in  1  one-cycle pulse from the debug/loader that begins execution.
REQ-006 stall_i  in  1  hazard-unit stall request; hold PC and IF/ID.
REQ-007 redirect_i  in  1  PC-source select from the EX flow-control logic (1 = redirect).
REQ-008 redirect_target_i  in  32  redirect address from the EX flow-control logic.
REQ-009 halt_detected_i  in  1  valid halt instruction present in EX.
REQ-010 imem_data_i  in  32  instruction word at imem_addr_o, combinational read.
REQ-011 imem_addr_o  out  32  current PC driven to instruction memory.
REQ-012 if_id_pc_o  out  32  PC of the instruction held in IF/ID.
REQ-013 if_id_pc_plus4_o  out  32  that PC + 4.
REQ-014 if_id_instr_o  out  32  instruction held in IF/ID; NOP (32'h0000_0013) when invalid.
REQ-015 if_id_valid_o  out  1  IF/ID holds a real instruction.
REQ-016 running_o  out  1  high in RUN state only.
REQ-017 halted_o  out  1  high in HALTED state only.
REQ-018 misaligned_o  out  1  sticky flag: a redirect target had bit 1 set.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and HALTED.
REQ-020 IDLE SHALL go to RUN on start_i; in IDLE the PC holds and IF/ID stays invalid.
REQ-021 In RUN, events SHALL be prioritised as: halt_detected_i, then redirect_i, then stall_i, then sequential fetch.
REQ-022 Sequential fetch SHALL capture {PC, PC+4, imem_data_i, valid=1} into IF/ID and update PC <= PC+4 in the same cycle.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 A redirect SHALL load PC <= {redirect_target_i[31:2], 2'b00} and flush IF/ID (valid=0, instr=NOP) the next cycle.
REQ-025 A redirect SHALL override a simultaneous stall_i.
REQ-026 A redirect whose target has bit 1 set SHALL set misaligned_o, which stays set until reset.
REQ-027 A stall SHALL hold the PC and every IF/ID field unchanged.
REQ-028 halt_detected_i in RUN SHALL freeze the PC, flush IF/ID, load the drain counter with DRAIN_CYCLES-1 and enter DRAIN; a simultaneous redirect or stall is ignored.
REQ-029 In DRAIN, the PC SHALL stay frozen, IF/ID SHALL stay invalid, all inputs SHALL be ignored, and the counter SHALL decrement each cycle.
REQ-030 DRAIN SHALL go to HALTED in the cycle after the counter reads 0.
REQ-031 HALTED SHALL be sticky until reset, ignoring start_i, redirect_i, stall_i and halt_detected_i.
REQ-032 start_i outside IDLE SHALL have no effect.
REQ-033 imem_addr_o SHALL equal the PC register at all times.
REQ-034 Fetch latency SHALL be 1 cycle: an instruction at PC appears in IF/ID the cycle after PC is presented.

Reset
REQ-035 On rst_ni=0 at a clock edge, from any state including mid-DRAIN or mid-redirect, the block SHALL set: state=IDLE, PC=RESET_PC, if_id_pc_o=0, if_id_pc_plus4_o=0, if_id_instr_o=NOP, if_id_valid_o=0, misaligned_o=0, drain counter=0.
REQ-036 After reset, running_o and halted_o SHALL both be 0.

Structure
REQ-037 A shared cpu_pkg SHALL hold fetch_state_e (IDLE/RUN/DRAIN/HALTED), the NOP_INSTR constant and the default RESET_PC.
REQ-038 The PC register with its next-PC mux SHALL be a sub-module, pc_register; the FSM and IF/ID register stay in fetch_stage.

Verification
REQ-039 Reset then start_i, no stall, imem returning addr^32'hA5A5_0000 -> IF/ID shows PC 0,4,8,... one cycle after each address, valid=1.
REQ-040 In RUN at PC=0x10, stall_i=1 and redirect_i=1 with target 0x40 in the same cycle -> next cycle PC=0x40, if_id_valid_o=0, if_id_instr_o=0x0000_0013.
REQ-041 Redirect target 0x0000_0102 -> PC=0x0000_0100 and misaligned_o=1; misaligned_o stays 1 through 10 further cycles.
REQ-042 halt_detected_i with redirect_i in the same cycle, DRAIN_CYCLES=2 -> PC frozen, IF/ID invalid, 2 cycles in DRAIN, then halted_o=1; a later start_i pulse leaves halted_o=1.
REQ-043 PC=0xFFFF_FFFC with sequential fetch -> next PC=0x0000_0000 and if_id_pc_plus4_o=0x0000_0000.
REQ-044 rst_ni=0 asserted during DRAIN -> next edge gives IDLE, PC=RESET_PC, if_id_valid_o=0, halted_o=0, running_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding, default reset PC.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Force an address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] i_addr);
      return i_addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with next-PC selection: redirect, sequential advance, or hold.
module pc_register
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_redirect,
   input  logic        i_advance,
   input  logic [31:0] i_target,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_plus4;

   // Sequential successor wraps naturally modulo 2^32.
   assign w_pc_plus4 = r_pc + 32'd4;

   // PC update: redirect has priority over sequential advance; otherwise hold.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc <= RESET_PC;
      end else if (i_redirect) begin
         r_pc <= word_align(i_target);
      end else if (i_advance) begin
         r_pc <= w_pc_plus4;
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: run-control FSM, PC sequencing and the IF/ID register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_target_i,
   input  logic        halt_detected_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] imem_addr_o,
   output logic [31:0] if_id_pc_o,
   output logic [31:0] if_id_pc_plus4_o,
   output logic [31:0] if_id_instr_o,
   output logic        if_id_valid_o,
   output logic        running_o,
   output logic        halted_o,
   output logic        misaligned_o
);

   localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   fetch_state_e     r_state;
   logic [CNT_W-1:0] r_drain_cnt;
   logic             r_running;
   logic             r_halted;
   logic             r_misaligned;

   logic [31:0] r_if_id_pc;
   logic [31:0] r_if_id_pc_plus4;
   logic [31:0] r_if_id_instr;
   logic        r_if_id_valid;

   logic [31:0] w_pc;
   logic [31:0] w_pc_plus4;
   logic        w_in_run;
   logic        w_halt_take;
   logic        w_redirect_take;
   logic        w_advance;

   // RUN-state event priority: halt, then redirect, then stall, then fetch.
   assign w_in_run        = (r_state == RUN);
   assign w_halt_take     = w_in_run && halt_detected_i;
   assign w_redirect_take = w_in_run && !halt_detected_i && redirect_i;
   assign w_advance       = w_in_run && !halt_detected_i && !redirect_i && !stall_i;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .i_redirect (w_redirect_take),
      .i_advance  (w_advance),
      .i_target   (redirect_target_i),
      .o_pc       (w_pc),
      .o_pc_plus4 (w_pc_plus4)
   );

   // Run-control FSM with registered status flags and drain countdown.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_drain_cnt <= '0;
         r_running   <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            RUN: begin
               if (halt_detected_i) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= CNT_LOAD;
                  r_running   <= 1'b0;
               end
            end
            DRAIN: begin
               // Leave one cycle after the counter has reached zero.
               if (r_drain_cnt == '0) begin
                  r_state  <= HALTED;
                  r_halted <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - CNT_W'(1);
               end
            end
            HALTED: begin
               r_state <= HALTED;
            end
            default: begin
               r_state   <= IDLE;
               r_running <= 1'b0;
               r_halted  <= 1'b0;
            end
         endcase
      end
   end

   // IF/ID register: flush on halt or redirect, capture on sequential fetch, else hold.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_if_id_pc       <= '0;
         r_if_id_pc_plus4 <= '0;
         r_if_id_instr    <= NOP_INSTR;
         r_if_id_valid    <= 1'b0;
      end else if (w_halt_take || w_redirect_take) begin
         r_if_id_instr <= NOP_INSTR;
         r_if_id_valid <= 1'b0;
      end else if (w_advance) begin
         r_if_id_pc       <= w_pc;
         r_if_id_pc_plus4 <= w_pc_plus4;
         r_if_id_instr    <= imem_data_i;
         r_if_id_valid    <= 1'b1;
      end
   end

   // Sticky flag for a taken redirect whose target is not word aligned.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_misaligned <= 1'b0;
      end else if (w_redirect_take && redirect_target_i[1]) begin
         r_misaligned <= 1'b1;
      end
   end

   assign imem_addr_o      = w_pc;
   assign if_id_pc_o       = r_if_id_pc;
   assign if_id_pc_plus4_o = r_if_id_pc_plus4;
   assign if_id_instr_o    = r_if_id_instr;
   assign if_id_valid_o    = r_if_id_valid;
   assign running_o        = r_running;
   assign halted_o         = r_halted;
   assign misaligned_o     = r_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] K   = 32'hA5A5_0000;

   typedef struct {
      logic        rst_n, start, stall, redir;
      logic [31:0] tgt;
      logic        halt;
      logic [31:0] pc, ipc, ip4, instr;
      logic        v, run, hlt, mis, chk_ipc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, start, stall, redir, halt;
   logic [31:0] tgt;
   logic [31:0] imem_data, imem_addr;
   logic [31:0] if_pc, if_pc4, if_instr;
   logic        if_valid, running, halted, misaligned;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t vecs[20];

   always #5 clk = ~clk;

   assign imem_data = imem_addr ^ K;

   fetch_stage #(
      .RESET_PC     (32'h0000_0000),
      .DRAIN_CYCLES (2)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .start_i           (start),
      .stall_i           (stall),
      .redirect_i        (redir),
      .redirect_target_i (tgt),
      .halt_detected_i   (halt),
      .imem_data_i       (imem_data),
      .imem_addr_o       (imem_addr),
      .if_id_pc_o        (if_pc),
      .if_id_pc_plus4_o  (if_pc4),
      .if_id_instr_o     (if_instr),
      .if_id_valid_o     (if_valid),
      .running_o         (running),
      .halted_o          (halted),
      .misaligned_o      (misaligned)
   );

   function automatic vec_t mk(
      input logic r, s, st, rd, input logic [31:0] t, input logic h,
      input logic [31:0] pc, ipc, ip4, ins,
      input logic v, ru, hl, mi, ck);
      vec_t x;
      x.rst_n = r;  x.start = s; x.stall = st; x.redir = rd; x.tgt = t; x.halt = h;
      x.pc = pc; x.ipc = ipc; x.ip4 = ip4; x.instr = ins;
      x.v = v; x.run = ru; x.hlt = hl; x.mis = mi; x.chk_ipc = ck;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, then sample just after the rising edge.
   task automatic step(input logic r, s, st, rd, input logic [31:0] t, input logic h);
      @(negedge clk);
      rst_n = r; start = s; stall = st; redir = rd; tgt = t; halt = h;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; redir = 1'b0; tgt = '0; halt = 1'b0;

      //             rst st  sl  rd  target        h    pc            if_pc         if_pc4        instr              v  run hlt mis chk
      vecs[0]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        NOP,               0, 0, 0, 0, 1);
      vecs[1]  = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        NOP,               0, 0, 0, 0, 1);
      vecs[2]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        NOP,               0, 1, 0, 0, 1);
      vecs[3]  = mk(1, 0, 0, 0, 32'h0,        0, 32'h4,        32'h0,        32'h4,        32'h0 ^ K,         1, 1, 0, 0, 1);
      vecs[4]  = mk(1, 0, 0, 0, 32'h0,        0, 32'h8,        32'h4,        32'h8,        32'h4 ^ K,         1, 1, 0, 0, 1);
      vecs[5]  = mk(1, 0, 0, 0, 32'h0,        0, 32'hC,        32'h8,        32'hC,        32'h8 ^ K,         1, 1, 0, 0, 1);
      vecs[6]  = mk(1, 0, 0, 0, 32'h0,        0, 32'h10,       32'hC,        32'h10,       32'hC ^ K,         1, 1, 0, 0, 1);
      vecs[7]  = mk(1, 0, 1, 0, 32'h0,        0, 32'h10,       32'hC,        32'h10,       32'hC ^ K,         1, 1, 0, 0, 1);
      vecs[8]  = mk(1, 0, 1, 1, 32'h40,       0, 32'h40,       32'h0,        32'h0,        NOP,               0, 1, 0, 0, 0);
      vecs[9]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h44,       32'h40,       32'h44,       32'h40 ^ K,        1, 1, 0, 0, 1);
      vecs[10] = mk(1, 0, 0, 1, 32'h102,      0, 32'h100,      32'h0,        32'h0,        NOP,               0, 1, 0, 1, 0);
      vecs[11] = mk(1, 0, 0, 0, 32'h0,        0, 32'h104,      32'h100,      32'h104,      32'h100 ^ K,       1, 1, 0, 1, 1);
      vecs[12] = mk(1, 0, 0, 1, 32'hFFFF_FFFC,0, 32'hFFFF_FFFC,32'h0,        32'h0,        NOP,               0, 1, 0, 1, 0);
      vecs[13] = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC,32'h0,        32'hFFFF_FFFC ^ K, 1, 1, 0, 1, 1);
      vecs[14] = mk(1, 0, 0, 0, 32'h0,        0, 32'h4,        32'h0,        32'h4,        32'h0 ^ K,         1, 1, 0, 1, 1);
      vecs[15] = mk(1, 0, 1, 1, 32'h80,       1, 32'h4,        32'h0,        32'h0,        NOP,               0, 0, 0, 1, 0);
      vecs[16] = mk(1, 1, 1, 1, 32'h200,      0, 32'h4,        32'h0,        32'h0,        NOP,               0, 0, 0, 1, 0);
      vecs[17] = mk(1, 0, 0, 0, 32'h0,        0, 32'h4,        32'h0,        32'h0,        NOP,               0, 0, 1, 1, 0);
      vecs[18] = mk(1, 1, 0, 0, 32'h0,        0, 32'h4,        32'h0,        32'h0,        NOP,               0, 0, 1, 1, 0);
      vecs[19] = mk(1, 1, 1, 1, 32'h200,      1, 32'h4,        32'h0,        32'h0,        NOP,               0, 0, 1, 1, 0);

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].rst_n, vecs[i].start, vecs[i].stall, vecs[i].redir, vecs[i].tgt, vecs[i].halt);
         chk($sformatf("v%0d.pc", i),      imem_addr,        vecs[i].pc);
         if (vecs[i].chk_ipc) begin
            chk($sformatf("v%0d.if_pc", i),  if_pc,          vecs[i].ipc);
            chk($sformatf("v%0d.if_pc4", i), if_pc4,         vecs[i].ip4);
         end
         chk($sformatf("v%0d.instr", i),   if_instr,         vecs[i].instr);
         chk($sformatf("v%0d.valid", i),   {31'b0, if_valid},   {31'b0, vecs[i].v});
         chk($sformatf("v%0d.running", i), {31'b0, running},    {31'b0, vecs[i].run});
         chk($sformatf("v%0d.halted", i),  {31'b0, halted},     {31'b0, vecs[i].hlt});
         chk($sformatf("v%0d.misalign", i),{31'b0, misaligned}, {31'b0, vecs[i].mis});
      end

      // Misaligned flag and HALTED both persist over ten more quiet cycles.
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 0, 32'h0, 0);
         chk($sformatf("sticky%0d.misalign", i), {31'b0, misaligned}, 32'h1);
         chk($sformatf("sticky%0d.halted", i),   {31'b0, halted},     32'h1);
         chk($sformatf("sticky%0d.pc", i),       imem_addr,           32'h4);
      end

      // Fresh run: reset clears everything, then sequential fetch of 0,4,8,C.
      step(0, 0, 0, 0, 32'h0, 0);
      chk("rst2.misalign", {31'b0, misaligned}, 32'h0);
      chk("rst2.halted",   {31'b0, halted},     32'h0);
      chk("rst2.pc",       imem_addr,           32'h0);
      step(1, 1, 0, 0, 32'h0, 0);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] a;
         a = 32'(k) * 32'd4;
         step(1, 0, 0, 0, 32'h0, 0);
         chk($sformatf("seq%0d.if_pc", k),  if_pc,             a);
         chk($sformatf("seq%0d.if_pc4", k), if_pc4,            a + 32'd4);
         chk($sformatf("seq%0d.instr", k),  if_instr,          a ^ K);
         chk($sformatf("seq%0d.valid", k),  {31'b0, if_valid}, 32'h1);
         chk($sformatf("seq%0d.pc", k),     imem_addr,         a + 32'd4);
      end

      // Halt into DRAIN, then reset while the drain counter is still running.
      step(1, 0, 0, 0, 32'h0, 1);
      chk("drain.running", {31'b0, running},  32'h0);
      chk("drain.halted",  {31'b0, halted},   32'h0);
      chk("drain.pc",      imem_addr,         32'h10);
      chk("drain.valid",   {31'b0, if_valid}, 32'h0);
      step(0, 0, 0, 0, 32'h0, 0);
      chk("drst.pc",      imem_addr,         32'h0);
      chk("drst.valid",   {31'b0, if_valid}, 32'h0);
      chk("drst.halted",  {31'b0, halted},   32'h0);
      chk("drst.running", {31'b0, running},  32'h0);
      chk("drst.if_pc",   if_pc,             32'h0);
      chk("drst.instr",   if_instr,          NOP);
      // Stays in IDLE without a start pulse, even if a halt is presented.
      step(1, 0, 0, 0, 32'h0, 1);
      chk("idle.pc",      imem_addr,         32'h0);
      chk("idle.running", {31'b0, running},  32'h0);
      chk("idle.halted",  {31'b0, halted},   32'h0);
      step(1, 0, 0, 0, 32'h0, 0);
      chk("idle2.halted", {31'b0, halted},   32'h0);
      chk("idle2.valid",  {31'b0, if_valid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
